// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key schedule: one shared round function expands the key over 10 cycles into an 11-entry store.
// Latency: done_o 10 cycles after an accepted start, reads 1 cycle; no backpressure, start_i ignored while busy.

module aes_key_expansion_round (
  input  logic [127:0] key_i,
  input  logic [31:0]  rcon_i,
  output logic [127:0] key_o
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Inverse in GF(2^8) as x^254 (maps 0 to 0), followed by the AES affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] p;
    logic [7:0] e;
    r = 8'h01;
    p = x;
    e = 8'hfe;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gf_mul(r, p);
      p = gf_mul(p, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  logic [31:0] w0, w1, w2, w3, rot, sub, n0, n1, n2, n3;

  always_comb begin
    w0  = key_i[127:96];
    w1  = key_i[95:64];
    w2  = key_i[63:32];
    w3  = key_i[31:0];
    rot = {w3[23:0], w3[31:24]};
    sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    n0  = w0 ^ sub ^ rcon_i;
    n1  = w1 ^ n0;
    n2  = w2 ^ n1;
    n3  = w3 ^ n2;
    key_o = {n0, n1, n2, n3};
  end

endmodule

module aes_key_sched_ctrl #(
  parameter int WIDTH = 128
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] key_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             keys_ready_o,
  input  logic             rd_en_i,
  input  logic [3:0]       rd_idx_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             rd_vld_o,
  output logic             rd_err_o
);

  typedef enum logic {IDLE, EXPAND} state_t;

  state_t           state, state_nxt;
  logic [3:0]       rnd;
  logic [3:0]       rnd_prev;
  logic [WIDTH-1:0] rk [0:10];
  logic [WIDTH-1:0] prev_key;
  logic [WIDTH-1:0] next_key;
  logic [7:0]       rcon_byte;

  always_comb begin
    case (rnd)
      4'd1:    rcon_byte = 8'h01;
      4'd2:    rcon_byte = 8'h02;
      4'd3:    rcon_byte = 8'h04;
      4'd4:    rcon_byte = 8'h08;
      4'd5:    rcon_byte = 8'h10;
      4'd6:    rcon_byte = 8'h20;
      4'd7:    rcon_byte = 8'h40;
      4'd8:    rcon_byte = 8'h80;
      4'd9:    rcon_byte = 8'h1b;
      4'd10:   rcon_byte = 8'h36;
      default: rcon_byte = 8'h00;
    endcase
  end

  // Guard the store index so rnd==0 never addresses past the array.
  always_comb begin
    rnd_prev = rnd - 4'd1;
    prev_key = (rnd_prev <= 4'd10) ? rk[rnd_prev] : '0;
  end

  aes_key_expansion_round u_round (
    .key_i  (prev_key),
    .rcon_i ({rcon_byte, 24'h000000}),
    .key_o  (next_key)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_i) state_nxt = EXPAND;
      EXPAND:  if (rnd == 4'd10) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy_o = (state == EXPAND);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rnd          <= 4'd0;
      done_o       <= 1'b0;
      keys_ready_o <= 1'b0;
      rd_data_o    <= '0;
      rd_vld_o     <= 1'b0;
      rd_err_o     <= 1'b0;
      for (int i = 0; i < 11; i++) rk[i] <= '0;
    end else begin
      done_o <= 1'b0;
      if (state == IDLE) begin
        if (start_i) begin
          rk[0]        <= key_i;
          rnd          <= 4'd1;
          keys_ready_o <= 1'b0;
        end
      end else begin
        rk[rnd] <= next_key;
        rnd     <= rnd + 4'd1;
        if (rnd == 4'd10) begin
          done_o       <= 1'b1;
          keys_ready_o <= 1'b1;
        end
      end

      // Reads see the pre-edge ready flag and store contents.
      rd_vld_o <= 1'b0;
      rd_err_o <= 1'b0;
      if (rd_en_i) begin
        if (keys_ready_o && (rd_idx_i <= 4'd10)) begin
          rd_data_o <= rk[rd_idx_i];
          rd_vld_o  <= 1'b1;
        end else begin
          rd_data_o <= '0;
          rd_err_o  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/aes_key_sched_ctrl.md
AES_KEY_SCHED_CTRL -- requirements
Module: aes_key_sched_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 128, giving the cipher key and round key width in bits; only 128 is supported.
REQ-002 The block SHALL have one clock and one reset: the reset is synchronous and active-high.
REQ-003 Port clk_i SHALL be an input, 1 bit wide: the single clock; all state updates on its rising edge.
REQ-004 Port rst_i SHALL be an input, 1 bit wide: the synchronous active-high reset.
REQ-005 Port start_i SHALL be an input, 1 bit wide: request to expand key_i; sampled only in IDLE.
REQ-006 Port key_i SHALL be an input, WIDTH bits wide: the cipher key, captured on the accepted start.
REQ-007 Port busy_o SHALL be an output, 1 bit wide: high while expansion is in progress.
REQ-008 Port done_o SHALL be an output, 1 bit wide: a one-cycle pulse when round key 10 has been written.
REQ-009 Port keys_ready_o SHALL be an output, 1 bit wide: a level, high when all 11 round keys are valid.
REQ-010 Port rd_en_i SHALL be an input, 1 bit wide: round-key read request.
REQ-011 Port rd_idx_i SHALL be an input, 4 bits wide: round-key index to read, 0..10.
REQ-012 Port rd_data_o SHALL be an output, WIDTH bits wide: registered read data.
REQ-013 Port rd_vld_o SHALL be an output, 1 bit wide: rd_data_o is valid this cycle.
REQ-014 Port rd_err_o SHALL be an output, 1 bit wide: the read was rejected (bad index, or keys not ready).

Function
REQ-015 The block SHALL instantiate exactly one combinational KeyExpansionRound (ports key_i, rcon_i, key_o) and reuse it once per cycle for all 10 rounds.
REQ-016 The block SHALL hold an 11-entry x WIDTH round-key store rk[0..10] and a 4-bit round counter rnd.
REQ-017 The FSM SHALL have exactly two states: IDLE and EXPAND.
REQ-018 IDLE with start_i=1 at edge T SHALL: set rk[0]<=key_i, rnd<=1, keys_ready_o<=0, and move to EXPAND.
REQ-019 In EXPAND, each edge SHALL: write rk[rnd] <= KeyExpansionRound(rk[rnd-1], rcon[rnd]), then increment rnd.
REQ-020 rcon[1..10] SHALL be {01,02,04,08,10,20,40,80,1b,36} placed in bits [31:24] of rcon_i, with the lower 24 bits zero.
REQ-021 At the edge that writes rk[10] (edge T+10), the FSM SHALL return to IDLE, set done_o<=1 for exactly one cycle, and set keys_ready_o<=1.
REQ-022 busy_o SHALL equal (state==EXPAND); it is high for exactly 10 cycles per expansion.
REQ-023 start_i while in EXPAND SHALL be ignored, with no restart and no effect on key_i capture.
REQ-024 start_i in the cycle done_o is high SHALL be accepted, because the FSM is already in IDLE; keys_ready_o then drops at the next edge.
REQ-025 A read with rd_en_i=1 at edge E SHALL produce rd_vld_o or rd_err_o, high for one cycle starting after edge E.
REQ-026 If keys_ready_o=1 and rd_idx_i<=10, the read SHALL return rd_data_o=rk[rd_idx_i] with rd_vld_o=1.
REQ-027 If rd_idx_i>10 or keys_ready_o=0, the read SHALL return rd_data_o=0 with rd_err_o=1 and rd_vld_o=0.
REQ-028 rd_data_o SHALL hold its last value while rd_en_i=0, and rd_vld_o and rd_err_o SHALL be 0 in that case.
REQ-029 A read in the same cycle as an accepted start SHALL use the pre-edge keys_ready_o value; a valid read returns the old key.

Reset
REQ-030 rst_i=1 at an edge SHALL force: state=IDLE, rnd=0, busy_o=0, done_o=0, keys_ready_o=0, rd_data_o=0, rd_vld_o=0, rd_err_o=0, and all rk entries=0.
REQ-031 Reset SHALL take priority over start_i and rd_en_i.
REQ-032 Reset mid-EXPAND SHALL abort the expansion with no done_o pulse; a new start is accepted on the first edge after rst_i falls.

Verification
REQ-033 Scenario FIPS-197 expansion: key_i=2b7e151628aed2a6abf7158809cf4f3c with a one-cycle start_i -> busy_o is high for 10 cycles, done_o pulses once, and reads of index 1/2/10 return a0fafe1788542cb123a339392a6c7605 / f2c295f27a96b9435935807a7359f67f / d014f9a8c9ee2589e13f0cc8b6630ca6, each with rd_vld_o=1.
REQ-034 Scenario index 0 readback: reading index 0 after done_o returns key_i; reading index 11 or 15 returns rd_err_o=1 and rd_data_o=0.
REQ-035 Scenario read during expansion: rd_en_i pulsed at cycle T+5 -> rd_err_o=1 and rd_vld_o=0; start_i re-asserted at T+5 -> done_o still at T+10 and the keys match the first key.
REQ-036 Scenario reset mid-operation: rst_i at T+4 -> busy_o=0 and keys_ready_o=0 next cycle and no done_o pulse; a restart with key 000102030405060708090a0b0c0d0e0f gives rk[10]=13111d7fe3944a17f307a78b4d2b30c5.
REQ-037 Scenario back-to-back expansions: start_i with key B asserted in the done_o cycle -> keys_ready_o falls, a second done_o comes 10 cycles later, and rk[10] corresponds to key B.
